divider_step_counter: RTL and testbench
=======================================

DIVIDER_STEP_COUNTER -- requirements
Module: divider_step_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, counter width; legal range 2..64.
REQ-002 The block SHALL have parameter AUTO_RELOAD, default 0: 0 = one-shot, 1 = reload at terminal and keep counting.
REQ-003 Clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset; Reset=0 forces the reset state immediately, independent of Clk.
REQ-005 Start  input  1  begin/restart a count sequence.
REQ-006 Abort  input  1  terminate the current sequence without Done.
REQ-007 En  input  1  count enable; RUN holds its value when low.
REQ-008 Dir  input  1  0 = count up 0->Limit, 1 = count down Limit->0; sampled only with Start.
REQ-009 Limit  input  WIDTH  terminal value, unsigned; sampled only with Start.
REQ-010 Out  output  WIDTH  current count, registered.
REQ-011 Busy  output  1  high while in RUN, registered.
REQ-012 Done  output  1  one-cycle registered pulse at sequence completion.

Function
REQ-013 The block SHALL implement states IDLE and RUN; Busy SHALL equal (state==RUN).
REQ-014 Edge priority SHALL be Abort > Start > count.
REQ-015 Abort=1 in any state: next state IDLE; Out holds; Done=0.
REQ-016 Start=1 with Abort=0, in any state: latch Dir and Limit; Out <= (Dir ? Limit : 0); next state RUN; Done=0; En is ignored on that edge.
REQ-017 In RUN with En=0: Out, state and latched Dir/Limit SHALL hold; Done=0.
REQ-018 In RUN with En=1 and Out != terminal: Out SHALL increment (up) or decrement (down) by 1. Terminal is latched Limit for up, 0 for down.
REQ-019 In RUN with En=1 and Out == terminal, AUTO_RELOAD=0: Done=1 for exactly the following cycle; next state IDLE; Out holds at the terminal value.
REQ-020 In RUN with En=1 and Out == terminal, AUTO_RELOAD=1: Done=1 for the following cycle; Out reloads to (Dir ? Limit : 0); state stays RUN.
REQ-021 An up sequence SHALL therefore span exactly Limit+1 enabled RUN edges from Start to Done; the same holds for a down sequence.
REQ-022 Limit=0 SHALL complete on the first enabled RUN edge, with Out staying 0.
REQ-023 Out SHALL never pass the terminal and never wrap modulo 2^WIDTH; Limit = 2^WIDTH-1 SHALL be legal.
REQ-024 In IDLE without Start, Out SHALL hold its last value and Done SHALL be 0 after any pulse ends.
REQ-025 Done SHALL never be high for two consecutive cycles unless AUTO_RELOAD=1 and Limit=0 with En continuously high.
REQ-026 All arithmetic SHALL be unsigned WIDTH-bit; no ripple or derived clocks; En SHALL be a synchronous qualifier only.

Reset
REQ-027 While Reset=0: state=IDLE, Out=0, Busy=0, Done=0, latched Dir=0, latched Limit=0.
REQ-028 Reset asserted mid-sequence SHALL abandon the sequence with no Done; after Reset deasserts, the block SHALL wait in IDLE for Start.

Verification
REQ-029 WIDTH=32, AUTO_RELOAD=0, Start with Dir=0, Limit=5, En=1 -> Out goes 0,1,2,3,4,5; Done high for 1 cycle after the 6th enabled edge; Busy then 0; Out=5.
REQ-030 Dir=1, Limit=3, En toggling 1,0,1,0... -> Out goes 3,2,1,0 advancing only on En=1 edges; Done after the 4th enabled edge; Out=0.
REQ-031 Limit=0, Start then En=1 -> Done on the first enabled edge; Out stays 0.
REQ-032 Mid-count at Out=7 with Limit=20: Start with Limit=2 -> Out=0 and no Done; completes at Out=2. Separately, Abort together with Start -> IDLE, Out holds, no Done.
REQ-033 AUTO_RELOAD=1, WIDTH=4, Dir=0, Limit=15, En=1 -> Out cycles 0..15 then 0 repeatedly with no overflow; Done pulses every 16 edges; Busy stays 1.
REQ-034 Reset=0 asynchronously mid-count at Out=9 -> Out=0, Busy=0, Done=0 before the next Clk edge; no Done after release.

Source files
------------

// File: rtl/divider_step_counter.sv
// Start/stop step counter: counts up 0->limit or down limit->0 under a count
// enable, with a one-cycle done pulse at the terminal value and optional auto-reload.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; out holds its last value
// RUN   | counting towards the terminal value on enabled edges
module divider_step_counter #(
  parameter int unsigned WIDTH       = 32,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nx;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] limit_nx;
  logic             dir_q;
  logic             dir_nx;
  logic             done_nx;
  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] reload;
  logic             at_term;
  logic             step;

  // terminal is 0 when counting down, the latched limit when counting up
  assign terminal = dir_q ? ZERO : limit_q;
  assign reload   = dir_q ? limit_q : ZERO;
  assign at_term  = (count == terminal);
  assign step     = (state == RUN) && en && !abort && !start;
  assign out      = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= ZERO;
      limit_q <= ZERO;
      dir_q   <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      limit_q <= limit_nx;
      dir_q   <= dir_nx;
      done    <= done_nx;
      busy    <= (state_nx == RUN);
    end
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else if (start) begin
      state_nx = RUN;
    end else if (step && at_term && !AUTO_RELOAD) begin
      state_nx = IDLE;
    end
  end

  always_comb begin
    count_nx = count;
    limit_nx = limit_q;
    dir_nx   = dir_q;
    done_nx  = 1'b0;
    if (!abort && start) begin
      limit_nx = limit;
      dir_nx   = dir;
      count_nx = dir ? limit : ZERO;
    end else if (step) begin
      if (at_term) begin
        done_nx = 1'b1;
        if (AUTO_RELOAD) begin
          count_nx = reload;
        end
      end else if (dir_q) begin
        count_nx = count - ONE;
      end else begin
        count_nx = count + ONE;
      end
    end
  end

endmodule

// File: tb/tb_divider_step_counter.sv
// Bench for divider_step_counter: a one-shot 32-bit instance and an auto-reload
// 4-bit instance, checked against a step-count reference model.
module tb_divider_step_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start0, abort0, en0, dir0;
  logic [31:0] limit0, out0;
  logic        busy0, done0;
  logic        start1, abort1, en1, dir1;
  logic [3:0]  limit1, out1;
  logic        busy1, done1;

  divider_step_counter #(.WIDTH(32), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .en(en0),
    .dir(dir0), .limit(limit0), .out(out0), .busy(busy0), .done(done0));

  divider_step_counter #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .en(en1),
    .dir(dir1), .limit(limit1), .out(out1), .busy(busy1), .done(done1));

  int tests = 0;
  int fails = 0;

  // model: number of enabled steps taken since start, plus latched dir/limit
  longint unsigned m_steps[2];
  longint unsigned m_limit[2];
  bit              m_dir[2];
  bit              m_act[2];
  bit              m_done[2];
  longint unsigned m_max[2] = '{64'hFFFF_FFFF, 64'd15};
  bit              m_ar[2]  = '{1'b0, 1'b1};

  function automatic longint unsigned m_out(int id);
    return m_dir[id] ? (m_limit[id] - m_steps[id]) : m_steps[id];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_steps[i] = 0; m_limit[i] = 0; m_dir[i] = 0; m_act[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_edge(int id, bit s, bit a, bit e, bit d, longint unsigned l);
    m_done[id] = 1'b0;
    if (a) begin
      m_act[id] = 1'b0;
    end else if (s) begin
      m_dir[id]   = d;
      m_limit[id] = l & m_max[id];
      m_steps[id] = 0;
      m_act[id]   = 1'b1;
    end else if (m_act[id] && e) begin
      if (m_steps[id] == m_limit[id]) begin
        m_done[id] = 1'b1;
        if (m_ar[id]) m_steps[id] = 0;
        else          m_act[id] = 1'b0;
      end else begin
        m_steps[id] = m_steps[id] + 1;
      end
    end
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(int id, string tag);
    if (id == 0) begin
      check($sformatf("%s.out0", tag), 64'(out0), 64'(m_out(0)));
      check($sformatf("%s.busy0", tag), 64'(busy0), 64'(m_act[0]));
      check($sformatf("%s.done0", tag), 64'(done0), 64'(m_done[0]));
    end else begin
      check($sformatf("%s.out1", tag), 64'(out1), 64'(m_out(1)));
      check($sformatf("%s.busy1", tag), 64'(busy1), 64'(m_act[1]));
      check($sformatf("%s.done1", tag), 64'(done1), 64'(m_done[1]));
    end
  endtask

  // called at a falling edge: drive one DUT, idle the other, clock once, check
  task automatic step(int id, bit s, bit a, bit e, bit d, longint unsigned l, string tag);
    if (id == 0) begin
      start0 = s; abort0 = a; en0 = e; dir0 = d; limit0 = l[31:0];
      start1 = 0; abort1 = 0; en1 = 0; dir1 = 0; limit1 = 4'd0;
    end else begin
      start1 = s; abort1 = a; en1 = e; dir1 = d; limit1 = l[3:0];
      start0 = 0; abort0 = 0; en0 = 0; dir0 = 0; limit0 = 32'd0;
    end
    @(posedge clk);
    model_edge(id, s, a, e, d, l);
    model_edge(1 - id, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check_dut(id, tag);
  endtask

  initial begin
    rst_n = 1'b1;
    start0 = 0; abort0 = 0; en0 = 0; dir0 = 0; limit0 = '0;
    start1 = 0; abort1 = 0; en1 = 0; dir1 = 0; limit1 = '0;
    model_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_dut(0, "reset");
    check_dut(1, "reset");
    rst_n = 1'b1;

    // up count to 5, done after the 6th enabled edge, then hold in idle
    step(0, 1, 0, 1, 0, 5, "up5_start");
    check("up5_first_out", 64'(out0), 64'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 0, "up5_run");
    check("up5_final_out", 64'(out0), 64'd5);
    check("up5_done", 64'(done0), 64'd1);
    step(0, 0, 0, 1, 0, 0, "up5_idle");

    // down from 3 with en toggling
    step(0, 1, 0, 0, 1, 3, "dn3_start");
    for (int i = 0; i < 8; i++) step(0, 0, 0, (i % 2) == 0, 0, 0, "dn3_run");
    check("dn3_final_out", 64'(out0), 64'd0);
    step(0, 0, 0, 1, 0, 0, "dn3_idle");

    // limit 0 completes on the first enabled edge
    step(0, 1, 0, 1, 0, 0, "lim0_start");
    step(0, 0, 0, 1, 0, 0, "lim0_run");
    check("lim0_done", 64'(done0), 64'd1);
    step(0, 0, 0, 1, 0, 0, "lim0_idle");

    // restart mid-count, then abort together with start
    step(0, 1, 0, 1, 0, 20, "rs_start");
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 0, "rs_run");
    check("rs_at7", 64'(out0), 64'd7);
    step(0, 1, 0, 1, 0, 2, "rs_restart");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, "rs_run2");
    step(0, 1, 0, 1, 0, 10, "ab_start");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, "ab_run");
    step(0, 1, 1, 1, 1, 9, "ab_abort_start");
    check("ab_hold", 64'(out0), 64'd3);
    step(0, 0, 0, 1, 0, 0, "ab_idle");

    // full-range limit, both directions
    step(0, 1, 0, 1, 1, 64'hFFFF_FFFF, "max_dn");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, "max_dn_run");
    step(0, 1, 0, 1, 0, 64'hFFFF_FFFF, "max_up");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, "max_up_run");

    // async reset mid-count at 9
    step(0, 1, 0, 1, 0, 20, "rst_start");
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0, 0, "rst_run");
    check("rst_at9", 64'(out0), 64'd9);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_out", 64'(out0), 64'd0);
    check("rst_async_busy", 64'(busy0), 64'd0);
    check("rst_async_done", 64'(done0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, "rst_after");

    // auto-reload 4-bit, limit 15 up: two full wraps
    step(1, 1, 0, 1, 0, 15, "ar_start");
    for (int i = 0; i < 34; i++) step(1, 0, 0, 1, 0, 0, "ar_run");
    step(1, 1, 0, 1, 1, 0, "ar_lim0_dn");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, 0, "ar_lim0_run");

    // randomized traffic on both instances
    for (int id = 0; id < 2; id++) begin
      for (int i = 0; i < 400; i++) begin
        bit s, a, e, d;
        longint unsigned l;
        s = ($urandom_range(0, 99) < 6);
        a = ($urandom_range(0, 99) < 3);
        e = ($urandom_range(0, 99) < 70);
        d = $urandom_range(0, 1);
        l = ($urandom_range(0, 9) == 0) ? m_max[id] - $urandom_range(0, 2)
                                         : longint'($urandom_range(0, 12));
        step(id, s, a, e, d, l, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
